// File: rtl/lsu_pkg.sv
// Shared encodings and default memory map for the load/store unit.
package lsu_pkg;

  // Access size encodings carried on core_hb_i
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_RSV  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Default slave indices
  localparam int SLV_ROM  = 0;
  localparam int SLV_RAM  = 1;
  localparam int SLV_UART = 2;

  // Default memory map
  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE  = 32'h0000_0100;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0100;
  localparam logic [31:0] RAM_SIZE  = 32'h0000_0100;
  localparam logic [31:0] UART_BASE = 32'h0000_0200;
  localparam logic [31:0] UART_SIZE = 32'h0000_0010;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] be_gen(input logic [1:0] hb, input logic [1:0] lsb);
    case (hb)
      HB_BYTE: be_gen = 4'b0001 << lsb;
      HB_HALF: be_gen = 4'b0011 << lsb;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes it may land on
  function automatic logic [31:0] wdata_gen(input logic [1:0] hb, input logic [31:0] wdata);
    case (hb)
      HB_BYTE: wdata_gen = {4{wdata[7:0]}};
      HB_HALF: wdata_gen = {2{wdata[15:0]}};
      default: wdata_gen = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational region decode: one-hot hit, hit flag and region-relative offset.
// Bounds are compared in 33 bits so a region ending at the top of the
// address space cannot wrap. Lowest index wins on overlapping regions.
module lsu_addr_decode
  import lsu_pkg::*;
#(
  parameter int NUM_SLV = 3
) (
  input  logic [31:0]           addr_i,
  input  logic [NUM_SLV*32-1:0] base_vec_i,
  input  logic [NUM_SLV*32-1:0] size_vec_i,
  output logic [NUM_SLV-1:0]    hit_oh_o,
  output logic                  hit_o,
  output logic [31:0]           offset_o
);

  logic [32:0] addr_ext;

  assign addr_ext = {1'b0, addr_i};

  // Scan from highest to lowest index so the lowest matching slave is kept
  always_comb begin
    hit_oh_o = '0;
    hit_o    = 1'b0;
    offset_o = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((size_vec_i[32*i +: 32] != 32'd0) &&
          (addr_ext >= {1'b0, base_vec_i[32*i +: 32]}) &&
          (addr_ext <= ({1'b0, base_vec_i[32*i +: 32]} +
                        {1'b0, size_vec_i[32*i +: 32]} - 33'd1))) begin
        hit_oh_o    = '0;
        hit_oh_o[i] = 1'b1;
        hit_o       = 1'b1;
        offset_o    = addr_i - base_vec_i[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: core data port to multi-slave peripheral bus with timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a core request; illegal requests go straight to RESP
// ST_ACCESS | bus cycle in flight, waiting for the selected slave's ack
// ST_RESP   | one-cycle response strobe to the core
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int                    NUM_SLV  = 3,
  parameter logic [NUM_SLV*32-1:0] BASE_VEC = {UART_BASE, RAM_BASE, ROM_BASE},
  parameter logic [NUM_SLV*32-1:0] SIZE_VEC = {UART_SIZE, RAM_SIZE, ROM_SIZE},
  parameter int                    TIMEOUT  = 15,
  parameter int                    CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [1:0]            core_hb_i,
  input  logic                  core_uns_i,
  input  logic [31:0]           core_addr_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_ready_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  output logic                  bus_req_o,
  output logic [NUM_SLV-1:0]    bus_cs_o,
  output logic [31:0]           bus_addr_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_be_o,
  output logic [31:0]           bus_wdata_o,
  input  logic [NUM_SLV*32-1:0] bus_rdata_i,
  input  logic [NUM_SLV-1:0]    bus_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           lsb_q, lsb_d;
  logic                 we_q, we_d;
  logic [1:0]           hb_q, hb_d;
  logic                 uns_q, uns_d;
  logic                 bus_req_q, bus_req_d;
  logic [NUM_SLV-1:0]   bus_cs_q, bus_cs_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic                 bus_we_q, bus_we_d;
  logic [3:0]           bus_be_q, bus_be_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NUM_SLV-1:0]   dec_hit_oh;
  logic                 dec_hit;
  logic [31:0]          dec_offset;
  logic                 misaligned;
  logic                 req_err;
  logic                 ack_sel;
  logic [31:0]          rdata_sel;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [31:0]          load_ext;

  lsu_addr_decode #(
    .NUM_SLV (NUM_SLV)
  ) u_decode (
    .addr_i     (core_addr_i),
    .base_vec_i (BASE_VEC),
    .size_vec_i (SIZE_VEC),
    .hit_oh_o   (dec_hit_oh),
    .hit_o      (dec_hit),
    .offset_o   (dec_offset)
  );

  assign misaligned = ((core_hb_i == HB_HALF) && core_addr_i[0]) ||
                      ((core_hb_i == HB_WORD) && (core_addr_i[1:0] != 2'b00));
  assign req_err    = misaligned || !dec_hit || (core_hb_i == HB_RSV);

  // Acks from slaves other than the selected one must not end the access
  assign ack_sel = |(bus_ack_i & bus_cs_q);

  // Pick the selected slave's read data
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (bus_cs_q[i]) rdata_sel = rdata_sel | bus_rdata_i[32*i +: 32];
    end
  end

  // Lane extraction and sign/zero extension of load data
  always_comb begin
    lane_b   = rdata_sel[7:0];
    lane_h   = rdata_sel[15:0];
    load_ext = rdata_sel;
    case (lsb_q)
      2'd0:    lane_b = rdata_sel[7:0];
      2'd1:    lane_b = rdata_sel[15:8];
      2'd2:    lane_b = rdata_sel[23:16];
      default: lane_b = rdata_sel[31:24];
    endcase
    lane_h = lsb_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    case (hb_q)
      HB_BYTE: load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      HB_HALF: load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = rdata_sel;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lsb_d       = lsb_q;
    we_d        = we_q;
    hb_d        = hb_q;
    uns_d       = uns_q;
    bus_req_d   = bus_req_q;
    bus_cs_d    = bus_cs_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          lsb_d = core_addr_i[1:0];
          we_d  = core_we_i;
          hb_d  = core_hb_i;
          uns_d = core_uns_i;
          if (req_err) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_cs_d    = dec_hit_oh;
            bus_addr_d  = dec_offset;
            bus_we_d    = core_we_i;
            bus_be_d    = be_gen(core_hb_i, core_addr_i[1:0]);
            bus_wdata_d = wdata_gen(core_hb_i, core_wdata_i);
          end
        end
      end

      ST_ACCESS: begin
        if (ack_sel || (cnt_q == CNT_LAST)) begin
          state_d     = ST_RESP;
          rvalid_d    = 1'b1;
          err_d       = !ack_sel;
          rdata_d     = (ack_sel && !we_q) ? load_ext : 32'd0;
          bus_req_d   = 1'b0;
          bus_cs_d    = '0;
          bus_addr_d  = '0;
          bus_we_d    = 1'b0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lsb_q       <= '0;
      we_q        <= 1'b0;
      hb_q        <= '0;
      uns_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_cs_q    <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lsb_q       <= lsb_d;
      we_q        <= we_d;
      hb_q        <= hb_d;
      uns_q       <= uns_d;
      bus_req_q   <= bus_req_d;
      bus_cs_q    <= bus_cs_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign core_ready_o  = (state_q == ST_IDLE);
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;
  assign bus_req_o     = bus_req_q;
  assign bus_cs_o      = bus_cs_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_we_o      = bus_we_q;
  assign bus_be_o      = bus_be_q;
  assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Sequential, parametrised load/store unit between the core data port and the peripheral bus.
- Decodes the address against NUM_SLV regions; generates one-hot chip select, region-relative address and byte enables.
- Runs a req/ack handshake with a timeout; returns lane-extracted, sign- or zero-extended load data to the core.
- Flags misaligned, unmapped, reserved-size and timed-out accesses instead of silently aliasing them.

Parameters:
- NUM_SLV, 3, number of bus slaves. Defaults: 0=ROM, 1=RAM, 2=UART.
- BASE_VEC, {32'h200,32'h100,32'h0}, packed NUM_SLV*32 region base addresses; slave i uses bits [32i+31:32i].
- SIZE_VEC, {32'h10,32'h100,32'h100}, packed NUM_SLV*32 region sizes in bytes.
- TIMEOUT, 15, maximum cycles in ACCESS without an ack before error; must be ≥1.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  core access request.
- core_we_i  in  1  1 = store, 0 = load.
- core_hb_i  in  2  size: 00 byte, 01 half, 10 word, 11 reserved.
- core_uns_i  in  1  load zero-extend when 1, sign-extend when 0.
- core_addr_i  in  32  byte address.
- core_wdata_i  in  32  store data, right-aligned.
- core_ready_o  out  1  request accepted this cycle.
- core_rvalid_o  out  1  one-cycle response strobe.
- core_rdata_o  out  32  load result.
- core_err_o  out  1  error qualifier, valid with core_rvalid_o.
- bus_req_o  out  1  bus access active.
- bus_cs_o  out  NUM_SLV  one-hot slave select.
- bus_addr_o  out  32  region-relative byte address.
- bus_we_o  out  1  write enable.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_rdata_i  in  NUM_SLV*32  per-slave read data.
- bus_ack_i  in  NUM_SLV  per-slave acknowledge.

Behaviour:
- Reset: asynchronous and active-low. All outputs go to 0, FSM goes to IDLE, counter clears. Reset mid-access drops bus_req_o immediately and produces no response.
- Decode: slave i hits when BASE_i ≤ addr ≤ BASE_i+SIZE_i-1, evaluated in 33-bit arithmetic so there is no wrap. On overlap the lowest index wins. No hit = unmapped.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0. hb=11 is an error.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - core_ready_o=1.
  - On core_req_i, latch addr, we, hb, uns and wdata.
  - Error (misaligned, unmapped or reserved size): go to RESP with err=1; no bus cycle, bus_req_o stays 0.
  - Otherwise: go to ACCESS and clear the counter.
- ACCESS:
  - bus_req_o=1; bus_cs_o = one-hot of the hit slave; bus_addr_o = addr-BASE.
  - Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - bus_wdata_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
  - All bus outputs stay stable until ack or timeout.
  - Only bus_ack_i of the selected slave counts; acks from other slaves are ignored.
  - On ack: register that slave's rdata and go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and no ack: go to RESP with err=1.
  - Ack and timeout in the same cycle: ack wins, err=0.
- RESP:
  - core_rvalid_o=1 for exactly one cycle; core_ready_o=0; return to IDLE.
  - Load data: byte/half lane selected by addr[1:0], then extended per uns.
  - core_rdata_o=0 on stores and on any error.
- Latency: request accepted in cycle 0, ACCESS in cycle 1, rvalid in cycle 2 with a same-cycle ack (minimum 3 cycles). Error responses take 2 cycles.
- Throughput: at most one access in flight. A new request is accepted only in IDLE, so back-to-back accesses are spaced ≥3 cycles apart.
- Registered outputs: bus outputs, core_rvalid_o, core_rdata_o and core_err_o. core_ready_o is combinational from state.

Decomposition:
- Shared package lsu_pkg: hb size encodings, FSM state encodings, default ROM/RAM/UART base and size constants, slave index constants.
- Sub-module lsu_addr_decode: combinational. Inputs: addr, BASE_VEC, SIZE_VEC. Outputs: one-hot hit vector, hit flag, region offset.
- Lane select/extension stays inline in lsu_ctrl.

Test Plan:
- Load word at 0x104, RAM acks in the first ACCESS cycle with 0xDEADBEEF → bus_cs_o=010, bus_addr_o=0x04, bus_be_o=1111; core_rvalid_o in cycle 2 with rdata=0xDEADBEEF, err=0.
- Signed byte load at 0x003, ROM word 0x80112233 → be=1000; rdata=0xFFFFFF80. The same access with uns=1 → rdata=0x00000080.
- Store half 0x1234ABCD to 0x102 → bus_be_o=1100, bus_wdata_o=0xABCDABCD, bus_we_o=1; response has rdata=0, err=0.
- Word load at 0x101 (misaligned) and load at 0x300 (unmapped) → bus_req_o never asserts; rvalid in cycle 1 with err=1.
- UART load at 0x200 with no ack → bus_req_o high for exactly 15 cycles, then rvalid with err=1. A variant acks on cycle 15 → err=0, data returned.
- Wrong-slave ack (bus_ack_i=001 during a RAM access) is ignored. rst_ni asserted mid-ACCESS → all outputs 0 asynchronously; after release no spurious rvalid.
